// File: rtl/icache_set_assoc.sv
// Read-only N-way set-associative instruction cache with true-LRU replacement.
// Hits answer one cycle after the lookup; misses fill a whole line word by word, then answer.
module icache_set_assoc #(
  parameter int CACHE_SIZE = 64,
  parameter int NUM_WAYS   = 4,
  parameter int NUM_BLOCKS = 2,
  parameter int BLOCK_SIZE = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        proc_valid,
  output logic        proc_ready,
  input  logic [31:0] proc_addr,
  output logic [31:0] proc_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic [31:0] mem_req_rdata,
  output logic        debug_miss
);

  localparam int LINE      = NUM_BLOCKS * BLOCK_SIZE;
  localparam int SETS      = CACHE_SIZE / (LINE * NUM_WAYS);
  localparam int OFF_BITS  = $clog2(LINE);
  localparam int IDX_BITS  = $clog2(SETS);
  localparam int IDX_W     = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int WSEL_BITS = $clog2(NUM_BLOCKS);
  localparam int WSEL_W    = (WSEL_BITS > 0) ? WSEL_BITS : 1;
  localparam int TAG_W     = 32 - OFF_BITS - IDX_BITS;
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, RESPOND, TURN} state_t;

  state_t            state;
  logic [31:0]       req_addr;
  logic [WSEL_W-1:0] word_cnt;

  logic [TAG_W-1:0]  tag_mem   [SETS][NUM_WAYS];
  logic              valid_mem [SETS][NUM_WAYS];
  logic [WAY_W-1:0]  age_mem   [SETS][NUM_WAYS];
  logic [31:0]       data_mem  [SETS][NUM_WAYS][NUM_BLOCKS];
  logic [31:0]       fill_buf  [NUM_BLOCKS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_wsel;
  logic [31:0]       line_base;

  assign req_idx   = (IDX_BITS > 0) ? req_addr[OFF_BITS +: IDX_W] : '0;
  assign req_tag   = req_addr[31 -: TAG_W];
  assign req_wsel  = (WSEL_BITS > 0) ? req_addr[2 +: WSEL_W] : '0;
  assign line_base = {req_addr[31:OFF_BITS], {OFF_BITS{1'b0}}};

  logic             hit;
  logic [WAY_W-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_mem[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Prefer the lowest empty way; only when the set is full fall back to the oldest age.
  logic             have_free;
  logic [WAY_W-1:0] victim;

  always_comb begin
    have_free = 1'b0;
    victim    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!have_free && !valid_mem[req_idx][w]) begin
        have_free = 1'b1;
        victim    = WAY_W'(w);
      end
    end
    if (!have_free) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_mem[req_idx][w] == WAY_W'(NUM_WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  logic             fill_last;
  logic             touch;
  logic [WAY_W-1:0] touch_way;
  logic [WAY_W-1:0] touch_age;

  assign fill_last = (state == FILL) && mem_req_ready && (word_cnt == WSEL_W'(NUM_BLOCKS - 1));
  assign touch     = ((state == LOOKUP) && hit) || fill_last;
  assign touch_way = (state == LOOKUP) ? hit_way : victim;
  assign touch_age = age_mem[req_idx][touch_way];

  // Line storage needs no reset: a way's contents only matter once its valid bit is set.
  always_ff @(posedge clk) begin
    if (state == FILL && mem_req_ready) fill_buf[word_cnt] <= mem_req_rdata;
    if (fill_last) begin
      tag_mem[req_idx][victim] <= req_tag;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        data_mem[req_idx][victim][b] <= (b == NUM_BLOCKS - 1) ? mem_req_rdata : fill_buf[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state         <= IDLE;
      req_addr      <= '0;
      word_cnt      <= '0;
      proc_ready    <= 1'b0;
      proc_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      debug_miss    <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_mem[s][w] <= 1'b0;
          age_mem[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      proc_ready <= 1'b0;
      debug_miss <= 1'b0;
      if (touch) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == touch_way) age_mem[req_idx][w] <= '0;
          else if (age_mem[req_idx][w] < touch_age) age_mem[req_idx][w] <= age_mem[req_idx][w] + WAY_W'(1);
        end
      end
      if (fill_last) valid_mem[req_idx][victim] <= 1'b1;
      unique case (state)
        IDLE: begin
          if (proc_valid) begin
            req_addr <= proc_addr;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            proc_ready <= 1'b1;
            proc_rdata <= data_mem[req_idx][hit_way][req_wsel];
            state      <= TURN;
          end else begin
            debug_miss    <= 1'b1;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= line_base;
            word_cnt      <= '0;
            state         <= FILL;
          end
        end
        FILL: begin
          if (mem_req_ready) begin
            if (word_cnt == WSEL_W'(NUM_BLOCKS - 1)) begin
              mem_req_valid <= 1'b0;
              state         <= RESPOND;
            end else begin
              word_cnt     <= word_cnt + WSEL_W'(1);
              mem_req_addr <= mem_req_addr + 32'd4;
            end
          end
        end
        RESPOND: begin
          proc_ready <= 1'b1;
          proc_rdata <= fill_buf[req_wsel];
          state      <= TURN;
        end
        TURN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc: an MRU-ordered tag list per set predicts hits and misses,
// a memory model answers fills with word[i] = 0xA000_0000 + i after a programmable delay.
module tb_icache_set_assoc;

  localparam int NUM_BLOCKS = 2;
  localparam int TB_WAYS    = 4;
  localparam int TB_SETS    = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        proc_valid = 1'b0;
  logic        proc_ready;
  logic [31:0] proc_addr = '0;
  logic [31:0] proc_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata = '0;
  logic        debug_miss;

  int errors = 0;
  int checks = 0;

  icache_set_assoc dut (
    .clk           (clk),
    .resetn        (resetn),
    .proc_valid    (proc_valid),
    .proc_ready    (proc_ready),
    .proc_addr     (proc_addr),
    .proc_rdata    (proc_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_rdata (mem_req_rdata),
    .debug_miss    (debug_miss)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  // Memory answers each request after mem_latency idle cycles, one word per handshake.
  int mem_latency = 0;
  int lat_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_req_ready) begin
      mem_req_ready = 1'b0;
      mem_req_rdata = 32'hBAD0_0000;
      lat_cnt = 0;
    end else if (mem_req_valid) begin
      if (lat_cnt >= mem_latency) begin
        mem_req_ready = 1'b1;
        mem_req_rdata = mem_word(mem_req_addr);
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // Model: per set, the resident tags ordered most- to least-recently used.
  logic [27:0] m_tag [TB_SETS][TB_WAYS];
  int          m_len [TB_SETS];

  task automatic model_reset();
    for (int s = 0; s < TB_SETS; s++) m_len[s] = 0;
  endtask

  task automatic model_access(input logic [31:0] addr, output bit hit);
    int s = int'(addr[3]);
    logic [27:0] t = addr[31:4];
    int pos = -1;
    for (int i = 0; i < m_len[s]; i++) if (m_tag[s][i] == t) pos = i;
    hit = (pos >= 0);
    if (!hit) begin
      if (m_len[s] < TB_WAYS) begin
        pos = m_len[s];
        m_len[s]++;
      end else begin
        pos = TB_WAYS - 1;
      end
    end
    for (int i = pos; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
    m_tag[s][0] = t;
  endtask

  bit          monitor_on = 1'b0;
  bit          exp_hit;
  logic [31:0] exp_rdata;
  logic [31:0] exp_base;
  int          ready_seen, misses_seen, reads_seen, valid_cycles;
  bit          prev_valid = 1'b0;
  bit          prev_hs = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] last_rdata;

  always @(negedge clk) begin
    if (monitor_on && !resetn) begin
      if (proc_ready) begin
        ready_seen++;
        checkOutput("proc_rdata", proc_rdata, exp_rdata);
      end
      if (debug_miss) misses_seen++;
      if (mem_req_valid) begin
        valid_cycles++;
        if (prev_valid && !prev_hs) checkOutput("mem_addr_stable", mem_req_addr, prev_addr);
        if (mem_req_ready) begin
          checkOutput("mem_addr", mem_req_addr, exp_base + 32'(4 * reads_seen));
          reads_seen++;
        end
      end
      prev_valid = mem_req_valid;
      prev_hs    = mem_req_valid && mem_req_ready;
      prev_addr  = mem_req_addr;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end
  end

  // lit_miss < 0 means no hand-computed miss count for this access.
  task automatic applyStimulus(input logic [31:0] addr, input int lit_miss);
    bit hit;
    int lat;
    model_access(addr, hit);
    exp_hit      = hit;
    exp_rdata    = mem_word(addr);
    exp_base     = {addr[31:3], 3'b000};
    ready_seen   = 0;
    misses_seen  = 0;
    reads_seen   = 0;
    valid_cycles = 0;
    @(negedge clk);
    proc_valid = 1'b1;
    proc_addr  = addr;
    @(posedge clk);
    #1 proc_addr = 32'hFFFF_FFF0;
    lat = 0;
    while (!proc_ready && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!proc_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: addr %h got no proc_ready, required one within 300 cycles", addr);
    end
    last_rdata = proc_rdata;
    proc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("ready_pulses", 32'(ready_seen), 32'd1);
    checkOutput("miss_pulses", 32'(misses_seen), hit ? 32'd0 : 32'd1);
    checkOutput("mem_reads", 32'(reads_seen), hit ? 32'd0 : 32'(NUM_BLOCKS));
    if (hit) begin
      checkOutput("hit_mem_idle", 32'(valid_cycles), 32'd0);
      checkOutput("hit_latency", 32'(lat - 1), 32'd1);
    end
    if (lit_miss >= 0) checkOutput("lit_miss", 32'(misses_seen), 32'(lit_miss));
  endtask

  logic [31:0] cold_addrs [8] = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h08, 32'h18, 32'h28, 32'h38};

  initial begin
    int lat;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("reset_proc_ready", 32'(proc_ready), 32'd0);
    checkOutput("reset_mem_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("reset_debug_miss", 32'(debug_miss), 32'd0);
    checkOutput("reset_proc_rdata", proc_rdata, 32'd0);
    checkOutput("reset_mem_addr", mem_req_addr, 32'd0);
    resetn = 1'b0;
    monitor_on = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(cold_addrs[i], 1);
    checkOutput("lit_cold_38", last_rdata, 32'hA000_000E);

    applyStimulus(32'h04, 0);
    checkOutput("lit_word1", last_rdata, 32'hA000_0001);

    for (int i = 0; i < 8; i++) applyStimulus(cold_addrs[i], 0);
    checkOutput("lit_hit_38", last_rdata, 32'hA000_000E);

    // Set 0 now runs 0x30,0x20,0x10,0x00 from most to least recent.
    applyStimulus(32'h40, 1);
    applyStimulus(32'h10, 0);
    applyStimulus(32'h20, 0);
    applyStimulus(32'h30, 0);
    applyStimulus(32'h18, 0);
    applyStimulus(32'h50, 1);
    applyStimulus(32'h44, 1);
    checkOutput("lit_word_44", last_rdata, 32'hA000_0011);
    applyStimulus(32'h20, 0);
    applyStimulus(32'h00, 1);
    applyStimulus(32'h30, 1);

    // Reset while the fill is in flight.
    monitor_on  = 1'b0;
    mem_latency = 3;
    @(negedge clk);
    proc_valid = 1'b1;
    proc_addr  = 32'h80;
    @(posedge clk);
    #1 proc_valid = 1'b0;
    lat = 0;
    while (!mem_req_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("fill_started", 32'(mem_req_valid), 32'd1);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("abort_mem_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("abort_proc_ready", 32'(proc_ready), 32'd0);
    resetn = 1'b0;
    model_reset();
    mem_latency = 0;
    monitor_on  = 1'b1;
    applyStimulus(32'h20, 1);
    applyStimulus(32'h18, 1);

    // Slow memory: five idle cycles before every word.
    mem_latency = 5;
    applyStimulus(32'h104, 1);
    checkOutput("lit_stall_word", last_rdata, 32'hA000_0041);
    applyStimulus(32'h100, 0);
    checkOutput("lit_stall_hit", last_rdata, 32'hA000_0040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
